// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared definitions for the RTC bus sequencer.
//   - Command codes written by the PicoBlaze on the command port.
//   - FSM state encoding. StGap exists only when RTC_BUS_GAP_EN is defined.
//   - Phase windows, inclusive, in slot phase units (0..31). Strobes are asserted inside them.
//   - Default command port address.
package rtc_bus_pkg;

    localparam logic [7:0] CMD_ABORT  = 8'h00;
    localparam logic [7:0] CMD_READ   = 8'h01;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_SINGLE = 8'h03;

    localparam logic [7:0] PORT_CMD_DEFAULT = 8'h10;

    localparam int unsigned ADDR_START = 0;
    localparam int unsigned ADDR_END   = 9;
    localparam int unsigned AS_START   = 1;
    localparam int unsigned AS_END     = 6;
    localparam int unsigned CS_START   = 12;
    localparam int unsigned CS_END     = 27;
    localparam int unsigned STB_START  = 14;
    localparam int unsigned STB_END    = 25;

`ifdef RTC_BUS_GAP_EN
    typedef enum logic [2:0] {StIdle, StSync, StXfer, StGap, StDone} state_e;
`else
    typedef enum logic [2:0] {StIdle, StSync, StXfer, StDone} state_e;
`endif

    function automatic logic in_window(int unsigned phase, int unsigned lo, int unsigned hi);
        return (phase >= lo) && (phase <= hi);
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// rtc_bus_sequencer_if: PicoBlaze command inputs and the RTC bus timing/strobe outputs.
//   master: sequencer side. It receives en_01/port_id/out_port and drives everything else.
//   slave : controller/observer side.
interface rtc_bus_sequencer_if #(
    parameter int unsigned SLOT_BITS = 5
);
    logic                 en_01;
    logic [7:0]           port_id;
    logic [7:0]           out_port;
    logic                 sync;
    logic [SLOT_BITS-1:0] cont_32;
    logic                 enable_cont_32;
    logic [4:0]           cont17;
    logic                 LE;
    logic                 AD_sel;
    logic                 AS;
    logic                 CS_n;
    logic                 RD_n;
    logic                 WR_n;
    logic                 busy;
    logic                 done;

    modport master (
        input  en_01, port_id, out_port,
        output sync, cont_32, enable_cont_32, cont17, LE, AD_sel, AS, CS_n, RD_n, WR_n,
        output busy, done
    );

    modport slave (
        output en_01, port_id, out_port,
        input  sync, cont_32, enable_cont_32, cont17, LE, AD_sel, AS, CS_n, RD_n, WR_n,
        input  busy, done
    );
endinterface

// File: rtl/rtc_slot_decoder.sv
// rtc_slot_decoder: combinational compare of the slot phase against the strobe windows.
//   phase_i    : current cont_32 value
//   addr_win_o : address phase (AD_sel window)
//   as_win_o   : address strobe window
//   cs_win_o   : chip-select window
//   stb_win_o  : read/write strobe window
module rtc_slot_decoder
    import rtc_bus_pkg::*;
#(
    parameter int unsigned SLOT_BITS = 5
) (
    input  logic [SLOT_BITS-1:0] phase_i,
    output logic                 addr_win_o,
    output logic                 as_win_o,
    output logic                 cs_win_o,
    output logic                 stb_win_o
);
    int unsigned phase;

    assign phase      = 32'(phase_i);
    assign addr_win_o = in_window(phase, ADDR_START, ADDR_END);
    assign as_win_o   = in_window(phase, AS_START, AS_END);
    assign cs_win_o   = in_window(phase, CS_START, CS_END);
    assign stb_win_o  = in_window(phase, STB_START, STB_END);
endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: decodes PicoBlaze command writes into RTC bus transfer sequences.
//   reloj  : system clock, rising edge
//   resetM : asynchronous active-low reset
//   bus    : command inputs (en_01, port_id, out_port), slot timing (sync, cont_32,
//            enable_cont_32, cont17), direction LE, RTC strobes (AD_sel, AS, CS_n, RD_n,
//            WR_n), and status (busy, done)
// Optional feature: when RTC_BUS_GAP_EN is defined, a one-slot idle GAP follows XFER.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter logic [7:0]  PORT_CMD  = PORT_CMD_DEFAULT,
    parameter int unsigned BURST_LEN = 17,
    parameter int unsigned SLOT_BITS = 5
) (
    input logic                 reloj,
    input logic                 resetM,
    rtc_bus_sequencer_if.master bus
);
    localparam logic [SLOT_BITS-1:0] PhaseMax = '1;
    localparam logic [SLOT_BITS-1:0] PhaseOne = {{(SLOT_BITS-1){1'b0}}, 1'b1};
    localparam logic [4:0]           LastIdx  = 5'(BURST_LEN - 1);

    state_e               state_q, state_d;
    logic [7:0]           cmd_q, cmd_d;
    logic                 le_q, le_d;
    logic [SLOT_BITS-1:0] cont_32_q, cont_32_d;
    logic                 en32_q, en32_d;
    logic [4:0]           cont17_q, cont17_d;
    logic                 ad_sel_q, ad_sel_d;
    logic                 as_q, as_d;
    logic                 cs_n_q, cs_n_d;
    logic                 rd_n_q, rd_n_d;
    logic                 wr_n_q, wr_n_d;

    logic busy, sync, cmd_wr, start_req, abort_req, last_slot, xfer_live;
    logic addr_win, as_win, cs_win, stb_win;

    rtc_slot_decoder #(
        .SLOT_BITS (SLOT_BITS)
    ) u_slot_decoder (
        .phase_i    (cont_32_q),
        .addr_win_o (addr_win),
        .as_win_o   (as_win),
        .cs_win_o   (cs_win),
        .stb_win_o  (stb_win)
    );

    always_comb begin
        busy = 1'b0;
        case (state_q)
            StSync, StXfer: busy = 1'b1;
`ifdef RTC_BUS_GAP_EN
            StGap:          busy = 1'b1;
`endif
            default:        busy = 1'b0;
        endcase
    end

    assign sync      = (state_q == StSync);
    assign cmd_wr    = bus.en_01 && (bus.port_id == PORT_CMD);
    assign start_req = cmd_wr && !busy &&
                       ((bus.out_port == CMD_READ) || (bus.out_port == CMD_WRITE) ||
                        (bus.out_port == CMD_SINGLE));
    assign abort_req = cmd_wr && busy && (bus.out_port == CMD_ABORT);
    assign last_slot = (cmd_q == CMD_SINGLE) || (cont17_q == LastIdx);

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        le_d     = le_q;
        cont17_d = cont17_q;

        case (state_q)
            StIdle, StDone: begin
                cont17_d = '0;
                if (start_req) begin
                    state_d = StSync;
                    cmd_d   = bus.out_port;
                    le_d    = (bus.out_port == CMD_READ);
                end else begin
                    state_d = StIdle;
                end
            end
            StSync: begin
                state_d  = StXfer;
                cont17_d = '0;
            end
            StXfer: begin
                if (en32_q) begin
                    if (last_slot) begin
                        cont17_d = '0;
`ifdef RTC_BUS_GAP_EN
                        state_d  = StGap;
`else
                        state_d  = StDone;
`endif
                    end else begin
                        cont17_d = cont17_q + 5'd1;
                    end
                end
            end
`ifdef RTC_BUS_GAP_EN
            StGap: begin
                if (en32_q) begin
                    state_d = StDone;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Abort wins over a coincident slot tick or burst end.
        if (abort_req) begin
            state_d  = StIdle;
            cont17_d = '0;
        end
    end

    // The slot restarts from 0 after sync, so a pending wrap tick from the old slot is dropped.
    assign cont_32_d = sync ? '0 : cont_32_q + PhaseOne;
    assign en32_d    = !sync && (cont_32_q == PhaseMax);

    // Strobes need XFER both now and next: this blanks the cycle leaving SYNC (stale phase)
    // and the cycle after XFER ends or is aborted.
    assign xfer_live = (state_q == StXfer) && (state_d == StXfer);
    assign ad_sel_d  = xfer_live && addr_win;
    assign as_d      = xfer_live && as_win;
    assign cs_n_d    = !(xfer_live && cs_win);
    assign wr_n_d    = !(xfer_live && stb_win && !le_q);
    assign rd_n_d    = !(xfer_live && stb_win && le_q);

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            state_q   <= StIdle;
            cmd_q     <= CMD_ABORT;
            le_q      <= 1'b0;
            cont_32_q <= '0;
            en32_q    <= 1'b0;
            cont17_q  <= '0;
            ad_sel_q  <= 1'b0;
            as_q      <= 1'b0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            le_q      <= le_d;
            cont_32_q <= cont_32_d;
            en32_q    <= en32_d;
            cont17_q  <= cont17_d;
            ad_sel_q  <= ad_sel_d;
            as_q      <= as_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
        end
    end

    assign bus.sync           = sync;
    assign bus.cont_32        = cont_32_q;
    assign bus.enable_cont_32 = en32_q;
    assign bus.cont17         = cont17_q;
    assign bus.LE             = le_q;
    assign bus.AD_sel         = ad_sel_q;
    assign bus.AS             = as_q;
    assign bus.CS_n           = cs_n_q;
    assign bus.RD_n           = rd_n_q;
    assign bus.WR_n           = wr_n_q;
    assign bus.busy           = busy;
    assign bus.done           = (state_q == StDone);
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: randomized scoreboard bench for rtc_bus_sequencer.
// Stimulus pushes the expected sync / strobe-pulse / end events of each command into a queue;
// a negedge monitor turns DUT activity into events, pops and compares them.
module tb_rtc_bus_sequencer;
    localparam logic [7:0] PORT_CMD   = 8'h10;
    localparam int         BURST_LEN  = 17;
    localparam logic [7:0] CMD_ABORT  = 8'h00;
    localparam logic [7:0] CMD_READ   = 8'h01;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_SINGLE = 8'h03;
`ifdef RTC_BUS_GAP_EN
    localparam int GAP = 32;
`else
    localparam int GAP = 0;
`endif
    localparam int KSync  = 0;
    localparam int KPulse = 1;
    localparam int KEnd   = 2;

    typedef struct {
        int kind;
        int idx;
        bit le;
        int off;
        bit done;
        int ad_exp;
        int as_exp;
    } exp_t;

    logic clk;
    logic resetM;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];

    rtc_bus_sequencer_if #(.SLOT_BITS(5)) bus ();

    rtc_bus_sequencer #(
        .PORT_CMD  (PORT_CMD),
        .BURST_LEN (BURST_LEN),
        .SLOT_BITS (5)
    ) dut (
        .reloj  (clk),
        .resetM (resetM),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endfunction

    function automatic bit pop_exp(input int kind, output exp_t e);
        e = '{default: 0};
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got event kind %0d, required none pending", kind);
            return 1'b0;
        end
        e = q.pop_front();
        if (e.kind != kind) begin
            errors++;
            $display("FAIL event_order: got event kind %0d, required kind %0d", kind, e.kind);
            return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void push_ev(input int kind, input int idx, input bit le, input int off,
                                    input bit done, input int ad_e, input int as_e);
        exp_t e;
        e.kind = kind; e.idx = idx; e.le = le; e.off = off;
        e.done = done; e.ad_exp = ad_e; e.as_exp = as_e;
        q.push_back(e);
    endfunction

    // ---------------- monitor ----------------
    bit prev_busy = 1'b0;
    bit prev_cs_n = 1'b1;
    bit mon_en    = 1'b0;
    int sync_cyc, cs_start, c17_fall, ph_fall, le_fall;
    int cs_cnt, rd_cnt, wr_cnt, ad_cnt, as_cnt, tick_cnt;

    always @(negedge clk) begin
        exp_t e;
        if (!resetM || !mon_en) begin
            prev_busy = 1'b0;
            prev_cs_n = 1'b1;
        end else begin
            if (bus.sync) begin
                sync_cyc = cyc;
                cs_cnt = 0; rd_cnt = 0; wr_cnt = 0; ad_cnt = 0; as_cnt = 0; tick_cnt = 0;
                if (pop_exp(KSync, e)) begin
                    chk("sync_le", int'(bus.LE), int'(e.le));
                    chk("sync_busy", int'(bus.busy), 1);
                end
            end else begin
                if (bus.AD_sel) ad_cnt++;
                if (bus.AS) as_cnt++;
                if (!bus.CS_n) cs_cnt++;
                if (!bus.RD_n) rd_cnt++;
                if (!bus.WR_n) wr_cnt++;
                if (bus.enable_cont_32 && (cyc - sync_cyc >= 2)) tick_cnt++;
                if (!bus.CS_n && prev_cs_n) begin
                    cs_start = cyc;
                    c17_fall = int'(bus.cont17);
                    ph_fall  = int'(bus.cont_32);
                    le_fall  = int'(bus.LE);
                end
                if (bus.CS_n && !prev_cs_n) begin
                    if (pop_exp(KPulse, e)) begin
                        chk("pulse_start", cs_start - sync_cyc, 14 + 32 * e.idx);
                        chk("pulse_cs_len", cs_cnt, 16);
                        chk("pulse_rd_len", rd_cnt, e.le ? 12 : 0);
                        chk("pulse_wr_len", wr_cnt, e.le ? 0 : 12);
                        chk("pulse_ad_len", ad_cnt, 10);
                        chk("pulse_as_len", as_cnt, 6);
                        chk("pulse_cont17", c17_fall, e.idx);
                        chk("pulse_phase", ph_fall, 13);
                        chk("pulse_le", le_fall, int'(e.le));
                        chk("pulse_ticks", tick_cnt, e.idx);
                    end
                    cs_cnt = 0; rd_cnt = 0; wr_cnt = 0; ad_cnt = 0; as_cnt = 0;
                end
                if (bus.done || (prev_busy && !bus.busy)) begin
                    if (pop_exp(KEnd, e)) begin
                        chk("end_done", int'(bus.done), int'(e.done));
                        chk("end_busy", int'(bus.busy), 0);
                        chk("end_offset", cyc - sync_cyc, e.off);
                        chk("end_idle", int'({bus.AD_sel, bus.AS, bus.CS_n, bus.RD_n, bus.WR_n}), 7);
                        chk("end_ad_cnt", ad_cnt, e.ad_exp);
                        chk("end_as_cnt", as_cnt, e.as_exp);
                        chk("end_stb_cnt", cs_cnt + rd_cnt + wr_cnt, 0);
                        chk("end_cont17", int'(bus.cont17), 0);
                    end
                end
            end
            prev_busy = bus.busy;
            prev_cs_n = bus.CS_n;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] pid, input logic [7:0] code);
        bus.en_01 = 1'b1; bus.port_id = pid; bus.out_port = code;
        tick();
        bus.en_01 = 1'b0; bus.port_id = 8'($urandom); bus.out_port = 8'($urandom);
    endtask

    // One-cycle write that must have no effect in the current (busy or idle) situation.
    task automatic drive_ignored(input bit busy_now);
        logic [7:0] pid;
        int v;
        v = $urandom_range(0, 2);
        pid = 8'($urandom);
        if (pid == PORT_CMD) pid = pid ^ 8'h01;
        if (v == 0) drive(pid, 8'($urandom));
        else if (v == 1) drive(PORT_CMD, 8'($urandom_range(4, 255)));
        else if (busy_now) drive(PORT_CMD, 8'($urandom_range(1, 3)));
        else drive(PORT_CMD, CMD_ABORT);
    endtask

    task automatic run_cycles(input int n, input bit busy_now, input int force_rel);
        for (int r = 0; r < n; r++) begin
            if (r == force_rel) drive(PORT_CMD, CMD_WRITE);
            else if ($urandom_range(0, 39) == 0) drive_ignored(busy_now);
            else tick();
        end
    endtask

    function automatic int ad_partial(input int ph);
        if (ph < 0) return 0;
        return (ph < 10) ? ph : 10;
    endfunction

    function automatic int as_partial(input int ph);
        if (ph <= 1) return 0;
        return (ph - 1 < 6) ? ph - 1 : 6;
    endfunction

    // abort_j < 0: run to completion. Otherwise abort in slot abort_j at phase ph
    // (ph < 0: abort during the sync cycle). Abort phases stay below the CS window.
    task automatic run_cmd(input logic [7:0] code, input int abort_j, input int ph,
                           input int force_rel);
        int n, off, a;
        bit le;
        n  = (code == CMD_SINGLE) ? 1 : BURST_LEN;
        le = (code == CMD_READ);
        push_ev(KSync, 0, le, 0, 1'b0, 0, 0);
        if (abort_j < 0) begin
            off = 2 + 32 * n + GAP;
            for (int k = 0; k < n; k++) push_ev(KPulse, k, le, 0, 1'b0, 0, 0);
            push_ev(KEnd, 0, le, off, 1'b1, 0, 0);
            drive(PORT_CMD, code);
            run_cycles(off, 1'b1, force_rel);
        end else begin
            a = (ph < 0) ? 0 : 1 + 32 * abort_j + ph;
            for (int k = 0; k < abort_j; k++) push_ev(KPulse, k, le, 0, 1'b0, 0, 0);
            push_ev(KEnd, 0, le, a + 1, 1'b0, ad_partial(ph), as_partial(ph));
            drive(PORT_CMD, code);
            run_cycles(a, 1'b1, force_rel);
            drive(PORT_CMD, CMD_ABORT);
        end
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_sync"}, int'(bus.sync), 0);
        chk({tag, "_cont_32"}, int'(bus.cont_32), 0);
        chk({tag, "_en32"}, int'(bus.enable_cont_32), 0);
        chk({tag, "_cont17"}, int'(bus.cont17), 0);
        chk({tag, "_LE"}, int'(bus.LE), 0);
        chk({tag, "_AD_sel"}, int'(bus.AD_sel), 0);
        chk({tag, "_AS"}, int'(bus.AS), 0);
        chk({tag, "_CS_n"}, int'(bus.CS_n), 1);
        chk({tag, "_RD_n"}, int'(bus.RD_n), 1);
        chk({tag, "_WR_n"}, int'(bus.WR_n), 1);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
    endtask

    initial begin
        int code, n, j, ph;
        bus.en_01 = 1'b0; bus.port_id = 8'h00; bus.out_port = 8'h00;
        resetM = 1'b1;
        #1 resetM = 1'b0;
        #1 check_reset("por");
        repeat (3) @(posedge clk);
        #3 resetM = 1'b1;
        tick();
        mon_en = 1'b1;
        run_cycles(5, 1'b0, -1);

        run_cmd(CMD_WRITE, -1, 0, -1);
        run_cmd(CMD_READ, -1, 0, -1);
        run_cmd(CMD_SINGLE, -1, 0, -1);
        run_cycles(2, 1'b0, -1);
        // Read burst: an ignored write command mid-burst, then abort in slot 5.
        run_cmd(CMD_READ, 5, 3, 100);
        run_cmd(CMD_SINGLE, 0, -1, -1);
        run_cmd(CMD_WRITE, BURST_LEN, 0, -1);

        for (int i = 0; i < 16; i++) begin
            code = $urandom_range(1, 3);
            n = (code == 3) ? 1 : BURST_LEN;
            if ($urandom_range(0, 3) == 0) begin
                j  = $urandom_range(0, n);
                ph = (j == n) ? 0 : $urandom_range(0, 11);
                if (j == 0 && $urandom_range(0, 3) == 0) ph = -1;
                run_cmd(8'(code), j, ph, -1);
            end else begin
                run_cmd(8'(code), -1, 0, -1);
            end
            run_cycles($urandom_range(0, 3), 1'b0, -1);
        end

        // Asynchronous reset in the middle of the slot-8 strobe of a read burst.
        push_ev(KSync, 0, 1'b1, 0, 1'b0, 0, 0);
        for (int k = 0; k < 8; k++) push_ev(KPulse, k, 1'b1, 0, 1'b0, 0, 0);
        drive(PORT_CMD, CMD_READ);
        run_cycles(14 + 32 * 8 + 5, 1'b1, -1);
        chk("pre_reset_cs_n", int'(bus.CS_n), 0);
        chk("pre_reset_cont17", int'(bus.cont17), 8);
        chk("pre_reset_queue", q.size(), 0);
        #2 resetM = 1'b0;
        #1 check_reset("async");
        repeat (2) @(posedge clk);
        #4 resetM = 1'b1;
        tick();
        run_cmd(CMD_SINGLE, -1, 0, -1);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
- Timing and control generator for the RTC multiplexed address/data bus.
- Decodes PicoBlaze command writes into bus transfer sequences.
- Produces the slot phase counter (cont_32), slot-end tick (enable_cont_32), transfer index (cont17), direction (LE) and sync consumed by the DIR_DATO bus mux.
- Drives the RTC strobes (CS_n, RD_n, WR_n, AS) directly.

Parameters:
- PORT_CMD, 8'h10: port_id that carries sequencer commands.
- BURST_LEN, 17: number of transfer slots in a burst command.
- SLOT_BITS, 5: phase counter width; slot length is 2**SLOT_BITS = 32 cycles.

Ports:
- reloj  in  1  system clock, rising edge.
- resetM  in  1  asynchronous active-low reset.
- en_01  in  1  PicoBlaze write strobe.
- port_id  in  8  PicoBlaze port address.
- out_port  in  8  PicoBlaze data; command code.
- sync  out  1  one-cycle pulse at command start.
- cont_32  out  SLOT_BITS  slot phase counter.
- enable_cont_32  out  1  slot-end tick.
- cont17  out  5  transfer index within the burst.
- LE  out  1  direction; 1 = read from RTC, 0 = write to RTC.
- AD_sel  out  1  1 = address phase on the bus.
- AS  out  1  address strobe, active-high.
- CS_n  out  1  chip select, active-low.
- RD_n  out  1  read strobe, active-low.
- WR_n  out  1  write strobe, active-low.
- busy  out  1  a sequence is in progress.
- done  out  1  one-cycle pulse at normal sequence completion.

Behaviour:
- Reset (resetM=0, async): sync=0, cont_32=0, enable_cont_32=0, cont17=0, LE=0, AD_sel=0, AS=0, CS_n=1, RD_n=1, WR_n=1, busy=0, done=0; FSM goes to IDLE.
- Command codes: 00 = abort, 01 = read burst, 02 = write burst, 03 = single write. All other codes are ignored.
- Accept condition: en_01=1, port_id==PORT_CMD, code in {01,02,03}, busy=0. On the next edge:
  - sync=1 for exactly 1 cycle.
  - Command is latched.
  - LE=1 for code 01, LE=0 for codes 02/03.
  - busy=1.
- Start codes (01/02/03) received while busy are ignored.
- Abort: code 00 while busy. Next edge: FSM→IDLE, strobes go idle, cont17=0, busy=0, no done.
- FSM states: IDLE→SYNC (1 cycle)→XFER→[GAP]→DONE (1 cycle, done=1)→IDLE.
- busy is 1 in SYNC, XFER and GAP; it is 0 in DONE, so busy falls on the same edge done rises.
- cont_32:
  - Cleared on the edge after a cycle with sync=1; otherwise increments and wraps 31→0.
  - Free-runs in IDLE.
- enable_cont_32: registered; equals 1 in the cycle after cont_32==31.
- cont17:
  - Cleared by sync; held at 0 in IDLE.
  - In XFER, increments on enable_cont_32.
  - For codes 01/02, at BURST_LEN-1 with enable_cont_32=1 it wraps to 0 and XFER ends.
  - Code 03 ends XFER at the first enable_cont_32; cont17 stays 0.
- Strobes are active only in XFER. Each is registered and reflects the cont_32 value of the previous cycle:
  - AD_sel=1 for phases 0..9.
  - AS=1 for phases 1..6.
  - CS_n=0 for phases 12..27.
  - WR_n=0 for phases 14..25 when LE=0.
  - RD_n=0 for phases 14..25 when LE=1.
  - Outside XFER: CS_n=RD_n=WR_n=1, AS=0, AD_sel=0.
- Simultaneous events: abort beats enable_cont_32 and burst end. A write command arriving in the DONE cycle is accepted (busy=0).
- Latency, accept to first CS_n low: 1 (sync) + 1 (counter clear) + 12 (phase) + 1 (register) = 15 cycles.

Optional Feature:
- Macro: RTC_BUS_GAP_EN.
- Defined: after XFER, the FSM enters GAP for one full slot (until the next enable_cont_32) with all strobes idle and busy=1, then goes to DONE. This guarantees RTC recovery time between back-to-back commands.
- Undefined: the GAP state does not exist; XFER goes directly to DONE.

Decomposition:
- Shared package rtc_bus_pkg holds:
  - command code constants CMD_ABORT/READ/WRITE/SINGLE;
  - FSM state encoding;
  - phase window constants (ADDR_START/END, AS_START/END, CS_START/END, STB_START/END);
  - PORT_CMD default.
- One natural sub-module: rtc_slot_decoder. It performs a combinational compare of cont_32 against the window constants; the parent registers its outputs.

Test Plan:
1. Release reset, write port 10/02 → sync high for 1 cycle, LE=0, busy=1. cont17 steps 0..16, 32 cycles each. 17 WR_n low pulses of 12 cycles; RD_n stays 1. done pulses 544±2 cycles after sync.
2. Write 10/01 → LE=1. 17 RD_n pulses with CS_n low for 16 cycles each. WR_n stays 1.
3. Write 10/03 → exactly 1 WR_n pulse, cont17 stays 0. done follows one slot after the sync clear.
4. During a read burst write 10/02 → ignored, LE stays 1. Then write 10/00 at cont17=5 → next edge all strobes idle, busy=0, no done pulse.
5. Drive resetM low at cont17=8 with CS_n=0 → all outputs take their reset values immediately, without waiting for a clock edge.
6. RTC_BUS_GAP_EN defined, command 03 → done delayed by 32 cycles versus scenario 3; strobes idle throughout the gap.
